// File: rtl/controle_hs_if.sv
// Handshake and control bundle between the BOBC sequencer and its datapath.
// The sequencer takes the slave side; the datapath/test driver takes the master side.
interface controle_hs_if;
    logic       inicio;
    logic       pronto;
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       lh;
    logic       ls;
    logic       inicia_op;
    logic       done;
    logic       ocupado;
    logic       erro;

    modport slave (
        input  inicio, pronto,
        output lx, m0, m1, m2, h, lh, ls, inicia_op, done, ocupado, erro
    );

    modport master (
        output inicio, pronto,
        input  lx, m0, m1, m2, h, lh, ls, inicia_op, done, ocupado, erro
    );
endinterface

// File: rtl/controle_hs.sv
// Handshaked BOBC sequencer: three operator steps, each waiting on pronto with a timeout.
// Outputs are registered from the next-state decode, so they change only on clock edges.
//
// state | meaning
// IDLE  | waiting for inicio, all outputs low
// LOADX | load X register
// ISSUE | pulse inicia_op for current step, clear timeout counter
// WAIT  | hold selects until pronto or timeout
// WRH   | load H, advance step or go to FINAL
// FINAL | adder path selects only
// WRS   | load S
// DONE  | one-cycle completion pulse
// ERR   | operator timed out, hold until inicio drops
module controle_hs #(
    parameter int TW      = 4,
    parameter int TIMEOUT = 10
) (
    input logic          ck,
    input logic          rst,
    controle_hs_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, LOADX, ISSUE, WAIT, WRH, FINAL, WRS, DONE, ERR
    } state_t;

    typedef struct packed {
        logic       lx;
        logic [1:0] m0;
        logic [1:0] m1;
        logic [1:0] m2;
        logic       h;
        logic       lh;
        logic       ls;
        logic       inicia_op;
        logic       done;
        logic       ocupado;
        logic       erro;
    } outs_t;

    localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

    state_t        st, st_n;
    logic [1:0]    passo, passo_n;
    logic [TW-1:0] cnt, cnt_n, cnt_inc;
    outs_t         outs, outs_n;

    // {m0, m1, m2, h}; index 3 is the final adder step
    function automatic logic [6:0] step_sel(input logic [1:0] p);
        case (p)
            2'd0:    return {2'b01, 2'b00, 2'b00, 1'b1};
            2'd1:    return {2'b10, 2'b00, 2'b11, 1'b0};
            2'd2:    return {2'b00, 2'b01, 2'b11, 1'b1};
            default: return {2'b11, 2'b00, 2'b11, 1'b0};
        endcase
    endfunction

    assign cnt_inc = cnt + TW'(1);

    always_comb begin
        st_n    = st;
        passo_n = passo;
        cnt_n   = cnt;
        case (st)
            IDLE:  if (bus.inicio) st_n = LOADX;
            LOADX: begin
                st_n    = ISSUE;
                passo_n = 2'd0;
            end
            ISSUE: begin
                st_n  = WAIT;
                cnt_n = '0;
            end
            WAIT: begin
                if (bus.pronto) begin
                    st_n = WRH;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == TMO) st_n = ERR;
                end
            end
            WRH: begin
                if (passo == 2'd2) begin
                    st_n = FINAL;
                end else begin
                    passo_n = passo + 2'd1;
                    st_n    = ISSUE;
                end
            end
            FINAL: st_n = WRS;
            WRS:   st_n = DONE;
            DONE: begin
                st_n    = IDLE;
                passo_n = 2'd0;
                cnt_n   = '0;
            end
            ERR: begin
                if (!bus.inicio) begin
                    st_n    = IDLE;
                    passo_n = 2'd0;
                    cnt_n   = '0;
                end
            end
            default: begin
                st_n    = IDLE;
                passo_n = 2'd0;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        outs_n = '0;
        case (st_n)
            LOADX: outs_n.lx = 1'b1;
            ISSUE: begin
                {outs_n.m0, outs_n.m1, outs_n.m2, outs_n.h} = step_sel(passo_n);
                outs_n.inicia_op = 1'b1;
            end
            WAIT:  {outs_n.m0, outs_n.m1, outs_n.m2, outs_n.h} = step_sel(passo_n);
            WRH: begin
                {outs_n.m0, outs_n.m1, outs_n.m2, outs_n.h} = step_sel(passo_n);
                outs_n.lh = 1'b1;
            end
            FINAL: {outs_n.m0, outs_n.m1, outs_n.m2, outs_n.h} = step_sel(2'd3);
            WRS: begin
                {outs_n.m0, outs_n.m1, outs_n.m2, outs_n.h} = step_sel(2'd3);
                outs_n.ls = 1'b1;
            end
            DONE:  outs_n.done = 1'b1;
            ERR:   outs_n.erro = 1'b1;
            default: outs_n = '0;
        endcase
        outs_n.ocupado = (st_n != IDLE) && (st_n != ERR);
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            st    <= IDLE;
            passo <= 2'd0;
            cnt   <= '0;
            outs  <= '0;
        end else begin
            st    <= st_n;
            passo <= passo_n;
            cnt   <= cnt_n;
            outs  <= outs_n;
        end
    end

    assign bus.lx        = outs.lx;
    assign bus.m0        = outs.m0;
    assign bus.m1        = outs.m1;
    assign bus.m2        = outs.m2;
    assign bus.h         = outs.h;
    assign bus.lh        = outs.lh;
    assign bus.ls        = outs.ls;
    assign bus.inicia_op = outs.inicia_op;
    assign bus.done      = outs.done;
    assign bus.ocupado   = outs.ocupado;
    assign bus.erro      = outs.erro;
endmodule

// File: tb/tb_controle_hs.sv
// Bench for controle_hs: runs are expanded from per-step pronto delays into a cycle plan
// of inputs and expected outputs, then replayed and checked every cycle.
module tb_controle_hs;
    localparam int TMO = 10;

    typedef struct packed {
        logic        rst;
        logic        inicio;
        logic        pronto;
        logic [13:0] exp;
    } ent_t;

    logic ck = 1'b0;
    logic rst;

    controle_hs_if bus ();
    controle_hs #(.TW(4), .TIMEOUT(TMO)) dut (.ck(ck), .rst(rst), .bus(bus));

    always #5 ck = ~ck;

    ent_t        plan[$];
    logic [13:0] exp_vec   = '0;
    logic        exp_valid = 1'b0;
    int          run_cyc   = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          n_lx, n_iop, n_lh, n_ls, n_done, done_cyc, err_cyc, ls_cyc;
    logic [31:0] iop_mask, lh_mask;

    wire [13:0] act = {bus.lx, bus.m0, bus.m1, bus.m2, bus.h, bus.lh, bus.ls,
                       bus.inicia_op, bus.done, bus.ocupado, bus.erro};

    // {m0, m1, m2, h} for steps 0..2 and the final adder step 3
    function automatic logic [6:0] sel(input int k);
        case (k)
            0:       return {2'b01, 2'b00, 2'b00, 1'b1};
            1:       return {2'b10, 2'b00, 2'b11, 1'b0};
            2:       return {2'b00, 2'b01, 2'b11, 1'b1};
            default: return {2'b11, 2'b00, 2'b11, 1'b0};
        endcase
    endfunction

    function automatic logic [13:0] v(input logic lx, input logic [6:0] s, input logic lh,
                                      input logic ls, input logic iop, input logic dn,
                                      input logic oc, input logic er);
        return {lx, s, lh, ls, iop, dn, oc, er};
    endfunction

    task automatic push(input logic r, input logic i, input logic p, input logic [13:0] e);
        plan.push_back(ent_t'({r, i, p, e}));
    endtask

    // One run: w[k] WAIT cycles without pronto before pronto on step k; w[k] >= TMO times out.
    // i0 = inicio on the start edge, ir = inicio afterwards, nz = pronto outside WAIT.
    task automatic build(input int w0, input int w1, input int w2,
                         input logic i0, input logic ir, input logic nz);
        int w[3];
        w[0] = w0; w[1] = w1; w[2] = w2;
        push(1'b0, i0, nz, v(1, 7'd0, 0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 3; k++) begin
            push(1'b0, ir, nz, v(0, sel(k), 0, 0, 1, 0, 1, 0));
            push(1'b0, ir, nz, v(0, sel(k), 0, 0, 0, 0, 1, 0));
            for (int j = 1; j <= w[k]; j++) begin
                if (j == TMO) begin
                    push(1'b0, ir, 1'b0, v(0, 7'd0, 0, 0, 0, 0, 0, 1));
                    return;
                end
                push(1'b0, ir, 1'b0, v(0, sel(k), 0, 0, 0, 0, 1, 0));
            end
            push(1'b0, ir, 1'b1, v(0, sel(k), 1, 0, 0, 0, 1, 0));
        end
        push(1'b0, ir, nz, v(0, sel(3), 0, 0, 0, 0, 1, 0));
        push(1'b0, ir, nz, v(0, sel(3), 0, 1, 0, 0, 1, 0));
        push(1'b0, ir, nz, v(0, 7'd0, 0, 0, 0, 1, 1, 0));
        push(1'b0, ir, nz, 14'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 14'd0);
    endtask

    task automatic play();
        n_lx = 0; n_iop = 0; n_lh = 0; n_ls = 0; n_done = 0;
        done_cyc = 0; err_cyc = 0; ls_cyc = 0; iop_mask = '0; lh_mask = '0;
        foreach (plan[i]) begin
            rst        = plan[i].rst;
            bus.inicio = plan[i].inicio;
            bus.pronto = plan[i].pronto;
            @(posedge ck);
            #1;
            run_cyc   = i + 1;
            exp_vec   = plan[i].exp;
            exp_valid = 1'b1;
        end
        @(negedge ck);
        #1;
        plan.delete();
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    always @(negedge ck) begin
        if (exp_valid) begin
            n_cmp++;
            if (act !== exp_vec) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got=%b want=%b", run_cyc, act, exp_vec);
            end
            if (bus.lx) n_lx++;
            if (bus.lh) n_lh++;
            if (bus.ls) n_ls++;
            if (bus.inicia_op) n_iop++;
            if (bus.done) n_done++;
            if (bus.done && done_cyc == 0) done_cyc = run_cyc;
            if (bus.ls && ls_cyc == 0) ls_cyc = run_cyc;
            if (bus.erro && err_cyc == 0) err_cyc = run_cyc;
            if (run_cyc < 32) begin
                if (bus.inicia_op) iop_mask[run_cyc] = 1'b1;
                if (bus.lh) lh_mask[run_cyc] = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus.inicio = 1'b0; bus.pronto = 1'b0;

        push(1'b1, 1'b0, 1'b0, 14'd0);
        push(1'b1, 1'b0, 1'b0, 14'd0);
        idle(5);
        play();
        chk("idle_busy_cycles", n_lx + n_iop + n_done, 0);

        // pronto tied high, single-cycle inicio
        build(0, 0, 0, 1'b1, 1'b0, 1'b1);
        chk("model_len_min", plan.size(), 14);
        play();
        chk("min_done_cyc", done_cyc, 13);
        chk("min_ls_cyc", ls_cyc, 12);
        chk("min_lx_count", n_lx, 1);
        chk("min_iop_cycles", int'(iop_mask), 32'h124);
        chk("min_lh_cycles", int'(lh_mask), 32'h490);
        chk("min_ls_count", n_ls, 1);
        idle(2);
        play();

        // three extra WAIT cycles per step
        build(3, 3, 3, 1'b1, 1'b0, 1'b0);
        play();
        chk("slow_done_cyc", done_cyc, 22);
        chk("slow_iop_count", n_iop, 3);
        chk("slow_lh_count", n_lh, 3);

        // operator hangs: timeout, ERR held while inicio stays high
        build(TMO, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("model_len_tmo", plan.size(), 13);
        repeat (3) push(1'b0, 1'b1, 1'b0, v(0, 7'd0, 0, 0, 0, 0, 0, 1));
        push(1'b0, 1'b0, 1'b0, 14'd0);
        idle(2);
        play();
        chk("tmo_err_cyc", err_cyc, 13);
        chk("tmo_lh_count", n_lh, 0);
        chk("tmo_ls_count", n_ls, 0);
        chk("tmo_done_count", n_done, 0);

        // pronto on the last allowed cycle, pronto noise in ISSUE/LOADX, inicio held high
        build(TMO - 1, 0, 0, 1'b1, 1'b1, 1'b1);
        play();
        chk("edge_done_cyc", done_cyc, 22);
        chk("edge_err_cyc", err_cyc, 0);
        build(0, 1, 2, 1'b1, 1'b1, 1'b0);
        play();
        chk("b2b_done_cyc", done_cyc, 16);
        idle(2);
        play();

        // reset in WAIT of step 1, then a fresh run
        build(0, 5, 0, 1'b1, 1'b0, 1'b0);
        while (plan.size() > 8) void'(plan.pop_back());
        push(1'b1, 1'b0, 1'b0, 14'd0);
        push(1'b0, 1'b0, 1'b0, 14'd0);
        play();
        chk("rst_done_count", n_done, 0);
        build(0, 0, 0, 1'b1, 1'b0, 1'b0);
        play();
        chk("rerun_done_cyc", done_cyc, 13);
        chk("rerun_lx_count", n_lx, 1);
        chk("rerun_iop_cycles", int'(iop_mask), 32'h124);

        exp_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/controle_hs.md
Name: controle_hs

Overview:
- Handshaked sequencer for the BOBC datapath (X register, H accumulator, S result register, three 2-bit operand muxes m0/m1/m2, and a multi-cycle operator that signals `pronto`).
- Replaces the fixed-timing sequence with a step loop that waits for `pronto` after each operator issue.
- Guards against a hung operator with a timeout, and exposes busy/error status to the top level.

Parameters:
- TW, 4, width of the wait-timeout counter.
- TIMEOUT, 10, number of WAIT cycles without `pronto` before entering ERR. Legal range: 1 .. 2^TW-1.

Ports:
- ck  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high; forces IDLE on the next edge
- inicio  in  1  start request, level, sampled only in IDLE and ERR
- pronto  in  1  operator result valid, sampled only in WAIT
- lx  out  1  load X register
- m0  out  2  operand mux 0 select
- m1  out  2  operand mux 1 select
- m2  out  2  operand mux 2 select
- h  out  1  operator mode select
- lh  out  1  load H register
- ls  out  1  load S register
- inicia_op  out  1  one-cycle operator start pulse
- done  out  1  one-cycle completion pulse
- ocupado  out  1  high in every state except IDLE and ERR
- erro  out  1  high while in ERR

Behaviour:
- Moore FSM. All outputs decode from state, step counter `passo` (2 bits) and timeout counter `cnt` (TW bits).
- Reset/IDLE outputs: every output is 0, including m0/m1/m2 = 00. `passo` = 0, `cnt` = 0.
- Step select encoding, held through ISSUE, WAIT and WRH:
  - passo 0: m0=01, m1=00, m2=00, h=1
  - passo 1: m0=10, m1=00, m2=11, h=0
  - passo 2: m0=00, m1=01, m2=11, h=1
  - FINAL/WRS: m0=11, m1=00, m2=11, h=0
- State transitions:
  - IDLE: inicio=1 -> LOADX; otherwise stay.
  - LOADX: lx=1; -> ISSUE; passo=0.
  - ISSUE: inicia_op=1; cnt cleared; -> WAIT unconditionally. `pronto` is ignored in ISSUE.
  - WAIT: pronto=1 -> WRH. Otherwise cnt+1; if cnt+1 == TIMEOUT -> ERR. If pronto=1 arrives on the timeout cycle, pronto wins.
  - WRH: lh=1; passo==2 -> FINAL; otherwise passo+1, -> ISSUE.
  - FINAL: single-cycle adder path, selects only; -> WRS.
  - WRS: ls=1; -> DONE.
  - DONE: done=1 for exactly one cycle; -> IDLE. If inicio is still high, the next run starts only from IDLE, i.e. at least one idle cycle between runs.
  - ERR: erro=1, all other outputs 0; stays until inicio=0, then -> IDLE.
- `inicio` is ignored while ocupado=1. `pronto` is ignored outside WAIT.
- rst has priority over every transition and is effective mid-run. No output glitches beyond the normal state decode.
- Minimum latency, with pronto in the first WAIT cycle: inicio sampled at edge 0 -> done high in cycle 13.
  - Cycle sequence: LOADX 1; per step ISSUE/WAIT/WRH (2-10); FINAL 11; WRS 12; DONE 13.
- Each WAIT cycle without pronto adds 1 cycle.
- Exactly one pulse per run on each of lx, ls and done. Exactly 3 pulses on each of lh and inicia_op.

Test Plan:
- Reset then idle with inicio=0 for 5 cycles -> all outputs 0, ocupado=0.
- inicio=1 for 1 cycle, pronto tied high -> pulses in order:
  - lx @1; inicia_op @2,5,8; lh @4,7,10; ls @12; done @13.
  - m-select sequence as tabled; ocupado high cycles 1-13.
- pronto delayed 3 cycles per step -> done @22; selects held stable through every WAIT; inicia_op still 3 single-cycle pulses.
- pronto never asserted, TIMEOUT=10 -> ERR entered 10 cycles after the first WAIT entry; erro=1, lh=ls=done=0. erro holds while inicio=1; IDLE one cycle after inicio drops.
- pronto on the exact timeout cycle -> WRH taken, no erro. Separately, a pronto pulse during ISSUE/LOADX is ignored.
- rst=1 while in WAIT of passo 1 -> IDLE next edge, all outputs 0. Then a fresh inicio -> full run restarting at passo 0.
